// File: rtl/mux2_4b.sv
// Two-input NBITS-wide selector: combinational out (zero latency) plus a flopped copy out_q (one cycle).
// No handshake; inputs are accepted every cycle and there is no backpressure.
module mux2_4b #(
  parameter int NBITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NBITS-1:0] in0,
  input  logic [NBITS-1:0] in1,
  input  logic             sel,
  output logic [NBITS-1:0] out,
  output logic [NBITS-1:0] out_q
);

  // out is independent of clk/rst so same-cycle consumers see it even before reset
  assign out = sel ? in1 : in0;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
    end else begin
      out_q <= out;
    end
  end

endmodule

// File: tb/tb_mux2_4b.sv
// Bench for mux2_4b: table-driven combinational vectors, hand-written register sequences,
// exhaustive sweep and a randomized run with occasional resets against a reference model.
module tb_mux2_4b;

  logic       clk = 1'b0;
  logic       clk_run = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] in0 = '0;
  logic [3:0] in1 = '0;
  logic       sel = 1'b0;
  logic [3:0] out;
  logic [3:0] out_q;

  int total = 0;
  int bad = 0;

  mux2_4b #(.NBITS(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .in0  (in0),
    .in1  (in1),
    .sel  (sel),
    .out  (out),
    .out_q(out_q)
  );

  // Clock only toggles once enabled, so the first checks run with no edge at all
  initial forever begin
    #5;
    if (clk_run) clk = ~clk;
  end

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       s;
    logic [3:0] e;
  } vec_t;

  function automatic logic [3:0] pick(input logic [3:0] a, input logic [3:0] b, input logic s);
    logic [3:0] ops [2];
    ops[0] = a;
    ops[1] = b;
    return ops[s];
  endfunction

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic s);
    in0 = a;
    in1 = b;
    sel = s;
    #1;
  endtask

  // Advance past one rising edge and settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t tab [6];
  logic [3:0] exp_q;
  logic [3:0] exp_o;
  logic       r;

  initial begin
    tab[0] = '{4'b0000, 4'b0000, 1'b0, 4'b0000};
    tab[1] = '{4'b1010, 4'b0101, 1'b1, 4'b0101};
    tab[2] = '{4'b1010, 4'b0101, 1'b0, 4'b1010};
    tab[3] = '{4'b1110, 4'b0111, 1'b0, 4'b1110};
    tab[4] = '{4'b1110, 4'b0111, 1'b1, 4'b0111};
    tab[5] = '{4'b1111, 4'b0000, 1'b0, 4'b1111};

    // Combinational path with the clock stopped
    for (int i = 0; i < 6; i++) begin
      drive(tab[i].a, tab[i].b, tab[i].s);
      chk($sformatf("comb_vec%0d", i), out, tab[i].e);
    end

    // Registered path: reset then the select/hold sequence
    clk_run = 1'b1;
    #2;
    rst = 1'b1;
    drive(4'b1010, 4'b0101, 1'b1);
    tick();
    chk("reset_out_q", out_q, 4'b0000);
    chk("out_during_reset", out, 4'b0101);
    rst = 1'b0;
    tick();
    chk("first_capture", out_q, 4'b0101);
    drive(4'b1010, 4'b0101, 1'b0);
    chk("hold_out_q", out_q, 4'b0101);
    chk("hold_out", out, 4'b1010);
    tick();
    chk("second_capture", out_q, 4'b1010);

    // Reset mid-stream
    drive(4'b0000, 4'b0111, 1'b1);
    tick();
    chk("pre_mid_reset", out_q, 4'b0111);
    rst = 1'b1;
    #1;
    chk("mid_reset_out_before", out, 4'b0111);
    tick();
    chk("mid_reset_out_q", out_q, 4'b0000);
    chk("mid_reset_out_after", out, 4'b0111);
    rst = 1'b0;
    tick();
    chk("post_reset_recover", out_q, 4'b0111);

    // Exhaustive sweep
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int s = 0; s < 2; s++) begin
          drive(4'(a), 4'(b), 1'(s));
          exp_o = pick(4'(a), 4'(b), 1'(s));
          chk($sformatf("sweep_out a=%0d b=%0d s=%0d", a, b, s), out, exp_o);
          tick();
          chk($sformatf("sweep_q a=%0d b=%0d s=%0d", a, b, s), out_q, exp_o);
        end
      end
    end

    // Randomized run with sporadic resets
    for (int n = 0; n < 300; n++) begin
      r = ($urandom_range(0, 9) == 0);
      rst = r;
      drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      exp_o = pick(in0, in1, sel);
      exp_q = r ? 4'b0000 : exp_o;
      chk($sformatf("rand_out %0d", n), out, exp_o);
      tick();
      chk($sformatf("rand_q %0d", n), out_q, exp_q);
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
